// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encoding and constants for the program-counter sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HOLD = 2'd2} state_t;
  localparam int ADDR_W = 32;
  localparam int JUMP_W = 26;
  localparam logic [ADDR_W-1:0] PC_INCR = 32'd4;
endpackage

// File: rtl/pc_next_calc.sv
// pc_next_calc: combinational next-PC select (taken branch > jump > sequential)
module pc_next_calc
  import pc_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [JUMP_W-1:0] jump_field,
  input  logic [ADDR_W-1:0] imm,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic              jump,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);
  logic [ADDR_W-1:0] pc_plus4;
  // carries out of bit 31 are dropped so the PC wraps modulo 2^32
  always_comb begin
    pc_plus4 = pc + PC_INCR;
    next_pc  = (branch & alu_zero) ? pc_plus4 + (imm << 2)
             : jump ? {pc_plus4[31:28], jump_field, 2'b00}
             : pc_plus4;
    redirect = next_pc != pc_plus4;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute PC sequencer; PC_SEQ_PERF_CNT_EN adds retire/redirect counters
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic        InstrValid,
  input  logic        ExecDone,
  input  logic        Branch,
  input  logic        ALUZero,
  input  logic        Jump,
  input  logic [31:0] SignExtImm32,
  output logic [31:0] CurrentPC
`ifdef PC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] RetireCount,
  output logic [31:0] RedirectCount
`endif
);
  state_t            state, state_next;
  logic [ADDR_W-1:0] next_pc;
  logic              redirect, fetch_done, exec_done;

  pc_next_calc u_next (
    .pc        (CurrentPC),
    .jump_field(Instr[JUMP_W-1:0]),
    .imm       (SignExtImm32),
    .branch    (Branch),
    .alu_zero  (ALUZero),
    .jump      (Jump),
    .next_pc   (next_pc),
    .redirect  (redirect)
  );

  // next-state decode; acks and completions outside their own state are ignored
  always_comb begin
    fetch_done = state == FETCH && IMemAck;
    exec_done  = state == EXEC && ExecDone;
    state_next = state == FETCH ? (IMemAck ? EXEC : FETCH)
               : state == EXEC  ? (ExecDone ? (Stall ? HOLD : FETCH) : EXEC)
               : (Stall ? HOLD : FETCH);
    IMemReq    = state == FETCH && !Reset;
    IMemAddr   = CurrentPC;
  end

  // state register
  always_ff @(posedge CLK)
    if (Reset) state <= FETCH;
    else state <= state_next;

  // PC and instruction latch; reset overrides any same-cycle ack or completion
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CurrentPC  <= RESET_PC;
      Instr      <= '0;
      InstrValid <= 1'b0;
    end else if (fetch_done) begin
      Instr      <= IMemData;
      InstrValid <= 1'b1;
    end else if (exec_done) begin
      CurrentPC  <= next_pc;
      InstrValid <= 1'b0;
    end
  end

`ifdef PC_SEQ_PERF_CNT_EN
  // retired-instruction and non-sequential-PC counters
  always_ff @(posedge CLK) begin
    if (Reset) begin
      RetireCount   <= '0;
      RedirectCount <= '0;
    end else if (exec_done) begin
      RetireCount   <= RetireCount + 32'd1;
      RedirectCount <= RedirectCount + {31'd0, redirect};
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1, Stall = 1'b0, IMemAck = 1'b0, ExecDone = 1'b0;
  logic        Branch = 1'b0, ALUZero = 1'b0, Jump = 1'b0;
  logic [31:0] IMemData = '0, SignExtImm32 = '0;
  logic        IMemReq, InstrValid;
  logic [31:0] IMemAddr, Instr, CurrentPC;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] RetireCount, RedirectCount;
`endif
  int tests = 0, failed = 0;

  pc_sequencer dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemData(IMemData), .Instr(Instr), .InstrValid(InstrValid),
    .ExecDone(ExecDone), .Branch(Branch), .ALUZero(ALUZero), .Jump(Jump),
    .SignExtImm32(SignExtImm32), .CurrentPC(CurrentPC)
`ifdef PC_SEQ_PERF_CNT_EN
    , .RetireCount(RetireCount), .RedirectCount(RedirectCount)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic run_instr(input logic [31:0] word, input logic br, input logic z,
                           input logic jp, input logic [31:0] imm);
    int n = 0;
    while (!IMemReq && n < 20) begin
      @(negedge CLK);
      n++;
    end
    tests++;
    if (!IMemReq) begin failed++; $display("FAIL fetch_wait: IMemReq=%b required 1", IMemReq); end
    IMemAck = 1'b1; IMemData = word;
    @(negedge CLK);
    IMemAck = 1'b0; IMemData = '0;
    tests++;
    if (InstrValid !== 1'b1 || Instr !== word) begin
      failed++; $display("FAIL latch: valid=%b instr=%h required 1 %h", InstrValid, Instr, word);
    end
    ExecDone = 1'b1; Branch = br; ALUZero = z; Jump = jp; SignExtImm32 = imm;
    @(negedge CLK);
    ExecDone = 1'b0; Branch = 1'b0; ALUZero = 1'b0; Jump = 1'b0; SignExtImm32 = '0;
  endtask

  task automatic expect_addr(input string name, input logic [31:0] exp);
    tests++;
    if (IMemReq !== 1'b1 || IMemAddr !== exp) begin
      failed++; $display("FAIL %s: req=%b addr=%h required 1 %h", name, IMemReq, IMemAddr, exp);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; IMemAck = 1'b1; IMemData = 32'hDEAD_BEEF;
    repeat (3) @(negedge CLK);
    tests++;
    if (IMemReq !== 1'b0 || CurrentPC !== 32'h0 || InstrValid !== 1'b0 || Instr !== 32'h0) begin
      failed++;
      $display("FAIL reset: req=%b pc=%h valid=%b instr=%h required 0 0 0 0", IMemReq, CurrentPC, InstrValid, Instr);
    end
    IMemAck = 1'b0; IMemData = '0; Reset = 1'b0;
    #1;
    expect_addr("reset_release", 32'h0);
  endtask

  task automatic test_streaming;
    IMemAck = 1'b1; ExecDone = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_addr("stream_fetch", 32'(4 * i));
      @(negedge CLK);
      tests++;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b1) begin
        failed++; $display("FAIL stream_exec: req=%b valid=%b required 0 1", IMemReq, InstrValid);
      end
      @(negedge CLK);
    end
    IMemAck = 1'b0; ExecDone = 1'b0;
    expect_addr("stream_end", 32'hC);
  endtask

  task automatic test_branch;
    run_instr(32'h0800_0040, 1'b0, 1'b0, 1'b1, '0);
    expect_addr("jump_low", 32'h100);
    run_instr(32'h0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
    expect_addr("branch_back", 32'hFC);
    run_instr(32'h0, 1'b1, 1'b0, 1'b0, 32'h10);
    expect_addr("branch_not_taken", 32'h100);
  endtask

  task automatic test_jump;
    run_instr(32'h0, 1'b1, 1'b1, 1'b0, 32'h03FF_FFBF);
    expect_addr("branch_far", 32'h1000_0000);
    run_instr(32'h0000_0040, 1'b0, 1'b0, 1'b1, '0);
    expect_addr("jump_region", 32'h1000_0100);
    run_instr(32'h0000_0040, 1'b1, 1'b0, 1'b1, 32'h5);
    expect_addr("branch_jump_prio", 32'h1000_0100);
  endtask

  task automatic test_wrap;
    run_instr(32'h0, 1'b1, 1'b1, 1'b0, 32'h3BFF_FFBE);
    expect_addr("to_top", 32'hFFFF_FFFC);
    run_instr(32'h0, 1'b0, 1'b0, 1'b0, '0);
    expect_addr("wrap", 32'h0);
  endtask

  task automatic test_ack_wait;
    for (int i = 0; i < 5; i++) begin
      Stall = i[0];
      ExecDone = 1'b1;
      @(negedge CLK);
      expect_addr("ack_wait", 32'h0);
    end
    Stall = 1'b0; ExecDone = 1'b0;
    run_instr(32'h0, 1'b0, 1'b0, 1'b0, '0);
    expect_addr("after_wait", 32'h4);
  endtask

  task automatic test_hold;
    IMemAck = 1'b1;
    @(negedge CLK);
    IMemAck = 1'b0; ExecDone = 1'b1; Stall = 1'b1;
    @(negedge CLK);
    ExecDone = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (IMemReq !== 1'b0 || InstrValid !== 1'b0 || CurrentPC !== 32'h8) begin
        failed++; $display("FAIL hold: req=%b valid=%b pc=%h required 0 0 00000008", IMemReq, InstrValid, CurrentPC);
      end
      IMemAck = 1'b1;
      if (i == 2) Stall = 1'b0;
      @(negedge CLK);
    end
    IMemAck = 1'b0;
    tests++;
    if (InstrValid !== 1'b0) begin failed++; $display("FAIL hold_ack_ignored: valid=%b required 0", InstrValid); end
    expect_addr("hold_exit", 32'h8);
  endtask

  task automatic test_reset_exec;
    IMemAck = 1'b1; IMemData = 32'h0000_0040;
    @(negedge CLK);
    IMemAck = 1'b0;
    ExecDone = 1'b1; Jump = 1'b1; Reset = 1'b1;
    @(negedge CLK);
    ExecDone = 1'b0; Jump = 1'b0;
    tests++;
    if (CurrentPC !== 32'h0 || InstrValid !== 1'b0 || Instr !== 32'h0 || IMemReq !== 1'b0) begin
      failed++;
      $display("FAIL reset_exec: pc=%h valid=%b instr=%h req=%b required 0 0 0 0", CurrentPC, InstrValid, Instr, IMemReq);
    end
`ifdef PC_SEQ_PERF_CNT_EN
    tests++;
    if (RetireCount !== 32'h0 || RedirectCount !== 32'h0) begin
      failed++; $display("FAIL reset_cnt: retire=%0d redirect=%0d required 0 0", RetireCount, RedirectCount);
    end
`endif
    Reset = 1'b0;
    #1;
    expect_addr("reset_exec_release", 32'h0);
  endtask

`ifdef PC_SEQ_PERF_CNT_EN
  task automatic test_perf_counters;
    for (int i = 0; i < 10; i++)
      case (i)
        2: run_instr(32'h0000_0040, 1'b0, 1'b0, 1'b1, '0);
        5: run_instr(32'h0, 1'b1, 1'b1, 1'b0, 32'h1);
        7: run_instr(32'h0000_0080, 1'b1, 1'b0, 1'b1, '0);
        default: run_instr(32'h0, 1'b1, 1'b0, 1'b0, 32'h3);
      endcase
    tests++;
    if (RetireCount !== 32'd10 || RedirectCount !== 32'd3) begin
      failed++; $display("FAIL perf_cnt: retire=%0d redirect=%0d required 10 3", RetireCount, RedirectCount);
    end
  endtask
`endif

  initial begin
    @(negedge CLK);
    test_reset;
    test_streaming;
    test_branch;
    test_jump;
    test_wrap;
    test_ack_wait;
    test_hold;
    test_reset_exec;
`ifdef PC_SEQ_PERF_CNT_EN
    test_perf_counters;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
